// File: rtl/mips_defs.sv
// Shared definitions for the fetch stage: FSM encodings, NOP word, reset PC.
package mips_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Clear the two low bits so the PC is always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction word, its PC and a valid flag.
// Priority: clear (reset contents) > load (new instruction) > bubble (drop valid).
module if_id_reg
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  // Next contents of the IF/ID slot.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (clear) begin
      instr_d = NOP_INSTR;
      pc_d    = 32'h0000_0000;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc_d    = pc_in;
      valid_d = 1'b1;
    end else if (bubble) begin
      valid_d = 1'b0;
    end
  end

  // Register the slot on the rising edge.
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc_q    <= pc_d;
    valid_q <= valid_d;
  end

  assign if_instr = instr_q;
  assign if_pc    = pc_q;
  assign if_valid = valid_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer feeding the IF/ID register.
// An instruction acked while decode is stalled is parked in a hold buffer
// (HOLD state) so it is neither lost nor refetched.
module pc_fetch_unit
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic         imem_req_q, imem_req_d;

  logic         ifid_load;
  logic         ifid_bubble;
  logic [31:0]  ifid_instr;

  // Next-state, PC load and IF/ID control decisions.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_instr  = imem_rdata;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (flush) begin
          ifid_bubble = 1'b1;
          pc_d        = word_align(next_pc);
        end else if (imem_ack && !stall) begin
          ifid_load = 1'b1;
          pc_d      = word_align(next_pc);
        end else if (imem_ack && stall) begin
          hold_d  = imem_rdata;
          state_d = HOLD;
        end else if (!stall) begin
          ifid_bubble = 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          ifid_bubble = 1'b1;
          pc_d        = word_align(next_pc);
          state_d     = FETCH;
        end else if (!stall) begin
          ifid_load  = 1'b1;
          ifid_instr = hold_q;
          pc_d       = word_align(next_pc);
          state_d    = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    imem_req_d = (state_d == FETCH);
  end

  // State, PC, hold buffer and registered request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      hold_q     <= NOP_INSTR;
      imem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      imem_req_q <= imem_req_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .clear    (rst),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .instr_in (ifid_instr),
    .pc_in    (pc_q),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .if_valid (if_valid)
  );

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + PC_STEP;
  assign imem_addr = pc_q;
  assign imem_req  = imem_req_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc;
  bit          m_started;   // first cycle after reset has elapsed
  bit          m_parked;    // an acked word is waiting for decode
  logic [31:0] m_parked_word;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  bit          m_valid;

  pc_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .next_pc    (next_pc),
    .pc_plus4   (pc_plus4),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .flush      (flush),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_valid   (if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8) return 32'h2108_0001;
    return (a * 32'h0001_0003) ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model before
  // the edge, then advance the model by the same rules the edge applies.
  task automatic cyc(input bit r, input bit seq, input logic [31:0] np,
                     input bit a, input bit s, input bit f);
    logic [31:0] npc;
    logic [31:0] npc_al;
    npc      = seq ? (m_pc + 32'd4) : np;
    npc_al   = {npc[31:2], 2'b00};
    rst        = r;
    next_pc    = npc;
    imem_ack   = a;
    imem_rdata = mem_word(m_pc);
    stall      = s;
    flush      = f;
    @(negedge clk);
    chk("pc",        pc,        m_pc);
    chk("pc_plus4",  pc_plus4,  m_pc + 32'd4);
    chk("imem_addr", imem_addr, m_pc);
    chk("imem_req",  {31'd0, imem_req}, {31'd0, (m_started && !m_parked)});
    chk("if_valid",  {31'd0, if_valid}, {31'd0, m_valid});
    chk("if_pc",     if_pc,     m_ipc);
    chk("if_instr",  if_instr,  m_instr);
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_started = 0; m_parked = 0; m_parked_word = 32'h0;
      m_valid = 0; m_instr = 32'h0; m_ipc = 32'h0;
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_parked) begin
      if (f) begin
        m_valid = 0; m_pc = npc_al; m_parked = 0;
      end else if (!s) begin
        m_instr = m_parked_word; m_ipc = m_pc; m_valid = 1;
        m_pc = npc_al; m_parked = 0;
      end
    end else begin
      if (f) begin
        m_valid = 0; m_pc = npc_al;
      end else if (a && !s) begin
        m_instr = mem_word(m_pc); m_ipc = m_pc; m_valid = 1; m_pc = npc_al;
      end else if (a && s) begin
        m_parked_word = mem_word(m_pc); m_parked = 1;
      end else if (!s) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1; next_pc = 0; imem_ack = 0; imem_rdata = 0; stall = 0; flush = 0;
    m_pc = 0; m_started = 0; m_parked = 0; m_parked_word = 0;
    m_instr = 0; m_ipc = 0; m_valid = 0;
    @(posedge clk); #1;
    cyc(1, 1, 0, 0, 0, 0);
    // Idle cycle, then zero-wait fetches 0 and 4 is delayed below.
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);          // fetch 0
    // Two wait states at 4.
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);          // ack 4
    // Ack at 8 while stalled -> parked, stay stalled, then release.
    cyc(0, 1, 0, 1, 1, 0);
    cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);          // 8 delivered, pc -> C
    chk("hold_instr", m_instr, 32'h2108_0001);
    cyc(0, 1, 0, 1, 0, 0);          // ack C
    // Ack at 10 with flush to 0x40.
    cyc(0, 0, 32'h40, 1, 0, 1);
    chk("flush_addr", imem_addr, 32'h40);
    cyc(0, 1, 0, 1, 1, 0);          // park 0x40
    cyc(0, 0, 32'h80, 0, 1, 1);     // flush wins over stall in hold
    // Wrap-around and alignment.
    cyc(0, 0, 32'hFFFF_FFFC, 0, 0, 1);
    cyc(0, 1, 0, 1, 0, 0);          // ack FFFF_FFFC -> pc 0
    cyc(0, 0, 32'h23, 1, 0, 0);     // pc -> 0x20
    cyc(0, 1, 0, 0, 0, 0);          // waiting
    cyc(1, 1, 0, 0, 0, 0);          // reset mid-wait
    cyc(0, 1, 0, 0, 0, 0);
    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) < 2),
          ($urandom_range(0, 99) < 80),
          $urandom,
          ($urandom_range(0, 99) < 70),
          ($urandom_range(0, 99) < 25),
          ($urandom_range(0, 99) < 10));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
